// File: rtl/vpu_stream_arbiter_pkg.sv
// Shared types for the VPU stream arbiter: instruction word, stream id width, FSM states.
// Includes the round-robin index helper used by the picker.
package vpu_stream_arbiter_pkg;

  localparam int STREAM_ID_WIDTH = 3;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [4:0]  vd;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic [31:0] scalar;
  } vpu_h2d_req_instr_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } arb_state_t;

  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/vpu_stream_arbiter_if.sv
// Requester, controller and completion signals of the stream arbiter.
// master = arbiter side, slave = environment side.
interface vpu_stream_arbiter_if
  import vpu_stream_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]                 req_valid_i;
  vpu_h2d_req_instr_t [NUM_REQ-1:0]   req_instr_i;
  logic [NUM_REQ-1:0]                 req_ready_o;

  logic                               ctrl_valid_o;
  vpu_h2d_req_instr_t                 ctrl_instr_o;
  logic [STREAM_ID_WIDTH-1:0]         ctrl_stream_id_o;
  logic                               ctrl_ready_i;

  logic                               resp_valid_i;
  logic [STREAM_ID_WIDTH-1:0]         resp_stream_id_i;
  logic                               resp_ready_o;

  logic [NUM_REQ-1:0]                 done_valid_o;
  logic [NUM_REQ-1:0]                 done_ready_i;

  logic                               busy_o;
  logic                               err_o;

  modport master (
    input  req_valid_i, req_instr_i, ctrl_ready_i, resp_valid_i, resp_stream_id_i, done_ready_i,
    output req_ready_o, ctrl_valid_o, ctrl_instr_o, ctrl_stream_id_o, resp_ready_o,
           done_valid_o, busy_o, err_o
  );

  modport slave (
    output req_valid_i, req_instr_i, ctrl_ready_i, resp_valid_i, resp_stream_id_i, done_ready_i,
    input  req_ready_o, ctrl_valid_o, ctrl_instr_o, ctrl_stream_id_o, resp_ready_o,
           done_valid_o, busy_o, err_o
  );

endinterface

// File: rtl/vpu_rr_picker.sv
// Round-robin pick: first requester after last_grant wins; purely combinational.
// Zero latency; grant is all-zero when nobody requests.
module vpu_rr_picker
  import vpu_stream_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx
);

  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (wrap_idx(int'(last_grant), k, N) == i)) begin
          found     = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/vpu_stream_arbiter.sv
// Round-robin arbiter issuing one instruction at a time to the VPU controller and routing its completion.
// Accept is combinational in idle; ctrl_valid one cycle later; done held until the owner takes it.
module vpu_stream_arbiter
  import vpu_stream_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vpu_stream_arbiter_if.master bus
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  if (NUM_REQ < 2 || NUM_REQ > (2 ** STREAM_ID_WIDTH)) begin : g_bad_num_req
    $error("vpu_stream_arbiter: NUM_REQ must be 2..2**STREAM_ID_WIDTH");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("vpu_stream_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

  arb_state_t                  state;
  logic [STREAM_ID_WIDTH-1:0]  last_grant;
  logic [STREAM_ID_WIDTH-1:0]  grant_id;
  logic [NUM_REQ-1:0]          grant_oh;
  vpu_h2d_req_instr_t          instr_q;
  logic [CNT_W-1:0]            cnt;
  logic                        ctrl_valid_q;
  logic [NUM_REQ-1:0]          done_valid_q;
  logic                        err_q;

  logic [NUM_REQ-1:0]          pick_grant;
  logic [STREAM_ID_WIDTH-1:0]  pick_idx;
  vpu_h2d_req_instr_t          pick_instr;
  logic                        resp_hit;
  logic                        timeout_hit;

  vpu_rr_picker #(
    .N (NUM_REQ),
    .W (STREAM_ID_WIDTH)
  ) u_picker (
    .req        (bus.req_valid_i),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .grant_idx  (pick_idx)
  );

  always_comb begin
    pick_instr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) pick_instr = bus.req_instr_i[i];
    end
  end

  assign resp_hit    = bus.resp_valid_i && (bus.resp_stream_id_i == grant_id);
  assign timeout_hit = (cnt == CNT_LAST);

  // Gated by rst_n so the accept strobe is dead while reset is held, even with requests pending.
  assign bus.req_ready_o      = (rst_n && state == S_IDLE) ? pick_grant : '0;
  assign bus.resp_ready_o     = (state == S_WAIT);
  assign bus.busy_o           = (state != S_IDLE);
  assign bus.ctrl_valid_o     = ctrl_valid_q;
  assign bus.ctrl_instr_o     = instr_q;
  assign bus.ctrl_stream_id_o = grant_id;
  assign bus.done_valid_o     = done_valid_q;
  assign bus.err_o            = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      last_grant   <= STREAM_ID_WIDTH'(NUM_REQ - 1);
      grant_id     <= '0;
      grant_oh     <= '0;
      instr_q      <= '0;
      cnt          <= '0;
      ctrl_valid_q <= 1'b0;
      done_valid_q <= '0;
      err_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|pick_grant) begin
            grant_id     <= pick_idx;
            grant_oh     <= pick_grant;
            instr_q      <= pick_instr;
            ctrl_valid_q <= 1'b1;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.ctrl_ready_i) begin
            ctrl_valid_q <= 1'b0;
            cnt          <= '0;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A matching response beats a timeout landing in the same cycle.
          if (resp_hit) begin
            done_valid_q <= grant_oh;
            state        <= S_DONE;
          end else if (timeout_hit) begin
            err_q      <= 1'b1;
            last_grant <= grant_id;
            state      <= S_IDLE;
          end else begin
            err_q <= bus.resp_valid_i;
            cnt   <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (|(done_valid_q & bus.done_ready_i)) begin
            done_valid_q <= '0;
            last_grant   <= grant_id;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/vpu_stream_arbiter.md
VPU_STREAM_ARBITER -- requirements
Module: vpu_stream_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requester ports (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum cycles spent waiting for a response (>=2).
REQ-003 SHALL have port clk  input  1  the single clock for all logic.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid_i  input  NUM_REQ  per-requester instruction valid.
REQ-006 SHALL have port req_instr_i  input  NUM_REQ x vpu_h2d_req_instr_t  per-requester instruction.
REQ-007 SHALL have port req_ready_o  output  NUM_REQ  per-requester accept; one-hot or zero.
REQ-008 SHALL have port ctrl_valid_o  output  1  instruction valid toward the VPU controller.
REQ-009 SHALL have port ctrl_instr_o  output  vpu_h2d_req_instr_t  latched instruction.
REQ-010 SHALL have port ctrl_stream_id_o  output  STREAM_ID_WIDTH  granted requester index, zero-extended.
REQ-011 SHALL have port ctrl_ready_i  input  1  controller ready.
REQ-012 SHALL have port resp_valid_i / resp_stream_id_i  input  1 / STREAM_ID_WIDTH  controller response.
REQ-013 SHALL have port resp_ready_o  output  1  response accept.
REQ-014 SHALL have port done_valid_o  output  NUM_REQ  per-requester completion, one-hot or zero; done_ready_i  input  NUM_REQ.
REQ-015 SHALL have port busy_o  output  1  high in any state other than S_IDLE; err_o  output  1  one-cycle error pulse.

Function
REQ-016 SHALL implement states S_IDLE, S_ISSUE, S_WAIT, S_DONE.
REQ-017 S_IDLE: if any req_valid_i is high, SHALL grant round-robin starting at last_grant+1 (modulo NUM_REQ), assert req_ready_o[g] combinationally that cycle, latch req_instr_i[g] and g, and go to S_ISSUE.
REQ-018 ctrl_valid_o SHALL be registered and high for the whole of S_ISSUE, so the earliest assertion is one cycle after acceptance; ctrl_instr_o/ctrl_stream_id_o SHALL be stable while it is high.
REQ-019 S_ISSUE: on ctrl_valid_o & ctrl_ready_i SHALL go to S_WAIT and clear the timeout counter.
REQ-020 S_WAIT: resp_ready_o SHALL be 1; on resp_valid_i with resp_stream_id_i == g SHALL go to S_DONE.
REQ-021 S_WAIT: a response with a mismatched stream id SHALL be consumed, pulse err_o for one cycle, and keep the state in S_WAIT.
REQ-022 S_WAIT: the counter SHALL increment each cycle without a matching response; when it reaches TIMEOUT_CYCLES-1 the block SHALL pulse err_o and go to S_IDLE without asserting done_valid_o.
REQ-023 A matching response arriving in the same cycle as the timeout SHALL win: go to S_DONE, no err_o.
REQ-024 S_DONE: done_valid_o[g] SHALL be held until done_ready_i[g], then last_grant SHALL be set to g and the state SHALL go to S_IDLE.
REQ-025 last_grant SHALL also update to g on the timeout exit.
REQ-026 Only one instruction SHALL be outstanding; req_ready_o SHALL be all-zero outside S_IDLE.
REQ-027 The counter width SHALL be $clog2(TIMEOUT_CYCLES)+1, with no wrap before expiry.
REQ-028 resp_ready_o SHALL be 0 outside S_WAIT; responses there SHALL be ignored with no error.

Reset
REQ-029 While rst_n is low SHALL force: state=S_IDLE, last_grant=NUM_REQ-1 (so requester 0 wins first), counter=0, latched instruction=0, and all outputs 0.
REQ-030 Reset asserted mid-operation SHALL abandon the transaction with no done_valid_o or err_o after release.

Structure
REQ-031 The state encoding localparams, vpu_h2d_req_instr_t and STREAM_ID_WIDTH SHALL live in VPU_PKG; NUM_REQ SHALL be checked against 2**STREAM_ID_WIDTH at elaboration.
REQ-032 The round-robin priority pick SHALL be a sub-module vpu_rr_picker (inputs request vector and last_grant; outputs one-hot grant and index), purely combinational.

Verification
REQ-033 Reset release with req_valid_i=4'b1111 -> grants in order 0,1,2,3,0, each completed via matching response and done_ready_i.
REQ-034 req_valid_i=4'b0100 accepted at cycle N -> ctrl_valid_o high at N+1, ctrl_stream_id_o=2; ctrl_ready_i low for 5 cycles -> ctrl_valid_o and ctrl_instr_o held constant throughout.
REQ-035 In S_WAIT for g=1, response with resp_stream_id_i=3 -> err_o one cycle, still busy; then stream id 1 -> done_valid_o=4'b0010.
REQ-036 TIMEOUT_CYCLES=8 with no response -> err_o 8 cycles after the handshake, back to S_IDLE, done_valid_o never high; then matching response on expiry cycle -> S_DONE, no err_o.
REQ-037 rst_n dropped asynchronously mid-clock in S_WAIT -> all outputs 0 immediately; after release requester 0 granted first.
REQ-038 done_ready_i held low 10 cycles -> done_valid_o held, req_ready_o all-zero, new req_valid_i not accepted until completion.
